// File: rtl/pulse_measure.sv
// pulse_measure
//   Sits behind the glitch filter. Turns the clean level sig_in into one-cycle
//   rise/fall event pulses and measures every high pulse in clock cycles. Each
//   result is offered on a valid/ready port. If a result completes while an
//   earlier one is still unaccepted, the new result is dropped and a sticky
//   overrun flag is raised.
//
//   Optional feature, enabled by defining PULSE_MEASURE_PERIOD_EN:
//     adds a rise-to-rise period measurement (period / period_valid).
//
//   Reset is synchronous and active-low (reset = 0 at a rising clock edge).
module pulse_measure #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] width,
  output logic             width_sat,
  output logic             width_valid,
  input  logic             width_ready,
  output logic             overrun
`ifdef PULSE_MEASURE_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
`endif
);

  // Counter limits.
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // ARM waits for the first low sample after reset, so that a pulse already
  // in progress at reset release is never measured.
  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // Saturating increment shared by the width and period counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      sat_inc = value;
    end else begin
      sat_inc = value + CNT_ONE;
    end
  endfunction

  state_t           r_state;
  logic             r_sig_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cnt_sat;
  logic             r_rise_pulse;
  logic             r_fall_pulse;
  logic [CNT_W-1:0] r_width;
  logic             r_width_sat;
  logic             r_width_valid;
  logic             r_overrun;

  logic             w_rise;
  logic             w_fall;
  logic             w_complete;
  logic             w_xfer;

  // Edge detection against the one-cycle-delayed level, plus handshake events.
  always_comb begin
    w_rise     = sig_in & ~r_sig_d;
    w_fall     = ~sig_in & r_sig_d;
    w_xfer     = r_width_valid & width_ready;
    w_complete = 1'b0;
    if (r_state == ST_HIGH) begin
      w_complete = w_fall;
    end else begin
      w_complete = 1'b0;
    end
  end

  // Delay sig_in by one cycle for edge detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= sig_in;
    end
  end

  // Measurement FSM: arm, wait for a rise, count high samples, emit edge pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_ARM;
      r_cnt        <= CNT_ZERO;
      r_cnt_sat    <= 1'b0;
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
    end else begin
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
      case (r_state)
        ST_ARM: begin
          // No pulses and no counting until the line has been seen low.
          if (!sig_in) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_ARM;
          end
        end
        ST_IDLE: begin
          if (w_rise) begin
            // The sample that shows the rise is the first high sample.
            r_state      <= ST_HIGH;
            r_cnt        <= CNT_ONE;
            r_cnt_sat    <= 1'b0;
            r_rise_pulse <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            // The count is final; the output stage picks it up this edge.
            r_state      <= ST_IDLE;
            r_fall_pulse <= 1'b1;
          end else if (sig_in) begin
            r_cnt <= sat_inc(r_cnt);
            if (r_cnt == CNT_MAX) begin
              r_cnt_sat <= 1'b1;
            end else begin
              r_cnt_sat <= r_cnt_sat;
            end
          end else begin
            r_state <= ST_HIGH;
          end
        end
        default: begin
          r_state <= ST_ARM;
        end
      endcase
    end
  end

  // Result register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_width       <= CNT_ZERO;
      r_width_sat   <= 1'b0;
      r_width_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (w_complete) begin
      if (!r_width_valid || w_xfer) begin
        // Slot empty, or being emptied at this very edge: take the new result.
        r_width       <= r_cnt;
        r_width_sat   <= r_cnt_sat;
        r_width_valid <= 1'b1;
      end else begin
        // Consumer still holds the old result: keep it, drop the new one.
        r_overrun <= 1'b1;
      end
    end else if (w_xfer) begin
      r_width_valid <= 1'b0;
    end else begin
      r_width_valid <= r_width_valid;
    end
  end

  assign rise_pulse  = r_rise_pulse;
  assign fall_pulse  = r_fall_pulse;
  assign width       = r_width;
  assign width_sat   = r_width_sat;
  assign width_valid = r_width_valid;
  assign overrun     = r_overrun;

`ifdef PULSE_MEASURE_PERIOD_EN
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_seen_rise;
  logic             w_rise_evt;

  // Only rises that also produce rise_pulse count as period boundaries.
  always_comb begin
    w_rise_evt = 1'b0;
    if (r_state == ST_IDLE) begin
      w_rise_evt = w_rise;
    end else begin
      w_rise_evt = 1'b0;
    end
  end

  // Free-running rise-to-rise counter; the first rise after arming only starts it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pcnt         <= CNT_ZERO;
      r_period       <= CNT_ZERO;
      r_period_valid <= 1'b0;
      r_seen_rise    <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (w_rise_evt) begin
        r_pcnt      <= CNT_ONE;
        r_seen_rise <= 1'b1;
        if (r_seen_rise) begin
          r_period       <= r_pcnt;
          r_period_valid <= 1'b1;
        end else begin
          r_period <= r_period;
        end
      end else begin
        r_pcnt <= sat_inc(r_pcnt);
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
`endif

endmodule

// File: tb/tb_pulse_measure.sv
// Testbench for pulse_measure: directed vector table, hand-written corner
// sequences (saturation on a narrow instance, period, reset mid-pulse) and a
// randomized run, all checked against an event-level reference model.
module tb_pulse_measure;

  localparam int CNT_W  = 16;
  localparam int MAXV   = (1 << CNT_W) - 1;
  localparam int MAXV4  = 15;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             sig_in = 1'b0;
  logic             width_ready = 1'b0;
  logic             rise_pulse, fall_pulse, width_sat, width_valid, overrun;
  logic [CNT_W-1:0] width;
`ifdef PULSE_MEASURE_PERIOD_EN
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [3:0]       period4;
  logic             period_valid4;
`endif

  logic       reset4 = 1'b0;
  logic       sig4   = 1'b0;
  logic       rdy4   = 1'b1;
  logic       rise4, fall4, sat4, valid4, ovr4;
  logic [3:0] width4;

  always #5 clock = ~clock;

  pulse_measure #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .sig_in(sig_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .width(width), .width_sat(width_sat), .width_valid(width_valid),
    .width_ready(width_ready), .overrun(overrun)
`ifdef PULSE_MEASURE_PERIOD_EN
    , .period(period), .period_valid(period_valid)
`endif
  );

  pulse_measure #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset4), .sig_in(sig4),
    .rise_pulse(rise4), .fall_pulse(fall4),
    .width(width4), .width_sat(sat4), .width_valid(valid4),
    .width_ready(rdy4), .overrun(ovr4)
`ifdef PULSE_MEASURE_PERIOD_EN
    , .period(period4), .period_valid(period_valid4)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: tracks armed/unarmed, the length of the current high run
  // (unbounded integer), the result slot, and absolute rise times.
  bit m_armed, m_prev, m_valid, m_sat, m_ovr, m_rise, m_fall, m_have_rise, m_pv;
  int m_run, m_width, m_last_rise, m_cyc, m_period;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit rdy);
    bit xfer, done, res_s;
    int res_w;
    m_cyc++;
    m_rise = 0; m_fall = 0; m_pv = 0;
    if (!r) begin
      m_armed = 0; m_prev = 0; m_run = 0; m_valid = 0; m_width = 0; m_sat = 0;
      m_ovr = 0; m_have_rise = 0; m_period = 0;
      return;
    end
    xfer = m_valid && rdy;
    done = 0; res_w = 0; res_s = 0;
    if (!m_armed) begin
      if (!s) m_armed = 1;
    end else if (s && !m_prev) begin
      m_rise = 1;
      m_run  = 1;
      if (m_have_rise) begin
        m_pv = 1;
        m_period = min_i(m_cyc - m_last_rise, MAXV);
      end
      m_have_rise = 1;
      m_last_rise = m_cyc;
    end else if (s && m_run > 0) begin
      m_run++;
    end else if (!s && m_prev && m_run > 0) begin
      m_fall = 1;
      done   = 1;
      res_w  = min_i(m_run, MAXV);
      res_s  = (m_run > MAXV);
      m_run  = 0;
    end
    if (done) begin
      if (!m_valid || xfer) begin
        m_valid = 1; m_width = res_w; m_sat = res_s;
      end else begin
        m_ovr = 1;
      end
    end else if (xfer) begin
      m_valid = 0;
    end
    m_prev = s;
  endtask

  task automatic compare_main();
    check("rise_pulse", rise_pulse, m_rise);
    check("fall_pulse", fall_pulse, m_fall);
    check("width_valid", width_valid, m_valid);
    check("overrun", overrun, m_ovr);
    if (m_valid) begin
      check("width", width, m_width);
      check("width_sat", width_sat, m_sat);
    end
`ifdef PULSE_MEASURE_PERIOD_EN
    check("period_valid", period_valid, m_pv);
    if (m_pv) check("period", period, m_period);
`endif
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit r, input bit s, input bit rdy);
    reset = r; sig_in = s; width_ready = rdy;
    model_edge(r, s, rdy);
    @(posedge clock);
    #1;
    compare_main();
    @(negedge clock);
  endtask

  typedef struct {
    bit r, s, rdy;
    bit er, ef, ev;
    int ew;
    bit es, eo;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int n, input bit r, input bit s, input bit rdy,
                     input bit er, input bit ef, input bit ev, input int ew,
                     input bit es, input bit eo);
    vec_t v;
    v.r = r; v.s = s; v.rdy = rdy; v.er = er; v.ef = ef; v.ev = ev;
    v.ew = ew; v.es = es; v.eo = eo;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    int lens[4];
    int pv_count;
    int pv_vals[2];
    bit s;
    bit cur;

    // Reset held with sig_in high, then ARM sees sig_in high for 4 cycles.
    add(2, 0,1,0, 0,0,0,0,0,0);
    add(4, 1,1,0, 0,0,0,0,0,0);
    add(2, 1,0,0, 0,0,0,0,0,0);
    // 5-sample pulse with ready high: one rise, one fall, valid for one cycle.
    add(1, 1,1,1, 1,0,0,0,0,0);
    add(4, 1,1,1, 0,0,0,0,0,0);
    add(1, 1,0,1, 0,1,1,5,0,0);
    add(1, 1,0,1, 0,0,0,0,0,0);
    add(1, 1,0,0, 0,0,0,0,0,0);
    // 3-sample pulse, one low sample, 7-sample pulse, ready low: overrun.
    add(1, 1,1,0, 1,0,0,0,0,0);
    add(2, 1,1,0, 0,0,0,0,0,0);
    add(1, 1,0,0, 0,1,1,3,0,0);
    add(1, 1,1,0, 1,0,1,3,0,0);
    add(6, 1,1,0, 0,0,1,3,0,0);
    add(1, 1,0,0, 0,1,1,3,0,1);
    add(1, 1,0,1, 0,0,0,0,0,1);
    add(1, 1,0,0, 0,0,0,0,0,1);
    // Reset, 6-sample result pending, 2-sample pulse completes as it transfers.
    add(1, 0,0,0, 0,0,0,0,0,0);
    add(1, 1,0,0, 0,0,0,0,0,0);
    add(1, 1,1,0, 1,0,0,0,0,0);
    add(5, 1,1,0, 0,0,0,0,0,0);
    add(1, 1,0,0, 0,1,1,6,0,0);
    add(1, 1,1,0, 1,0,1,6,0,0);
    add(1, 1,1,0, 0,0,1,6,0,0);
    add(1, 1,0,1, 0,1,1,2,0,0);
    add(1, 1,0,1, 0,0,0,0,0,0);

    @(negedge clock);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].rdy);
      check($sformatf("tbl%0d_rise", i), rise_pulse, vecs[i].er);
      check($sformatf("tbl%0d_fall", i), fall_pulse, vecs[i].ef);
      check($sformatf("tbl%0d_valid", i), width_valid, vecs[i].ev);
      check($sformatf("tbl%0d_ovr", i), overrun, vecs[i].eo);
      if (vecs[i].ev) begin
        check($sformatf("tbl%0d_width", i), width, vecs[i].ew);
        check($sformatf("tbl%0d_sat", i), width_sat, vecs[i].es);
      end
    end

    // Saturation on a 4-bit instance (main DUT held in reset meanwhile).
    lens[0] = 1; lens[1] = 15; lens[2] = 16; lens[3] = 20;
    reset4 = 1'b0; sig4 = 1'b0; rdy4 = 1'b1;
    step(0, 0, 0);
    reset4 = 1'b1;
    step(0, 0, 0);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < lens[p]; k++) begin
        sig4 = 1'b1;
        step(0, 0, 0);
      end
      sig4 = 1'b0;
      step(0, 0, 0);
      check($sformatf("sat4_valid_len%0d", lens[p]), valid4, 1);
      check($sformatf("sat4_width_len%0d", lens[p]), width4, (lens[p] > MAXV4) ? MAXV4 : lens[p]);
      check($sformatf("sat4_sat_len%0d", lens[p]), sat4, (lens[p] > MAXV4) ? 1 : 0);
      step(0, 0, 0);
      check($sformatf("sat4_drained_len%0d", lens[p]), valid4, 0);
    end
    check("sat4_overrun", ovr4, 0);

    // Rises at cycles 10, 18 and 30 after reset release; reset hits mid-pulse.
    step(0, 0, 1);
    pv_count = 0; pv_vals[0] = 0; pv_vals[1] = 0;
    for (int c = 1; c <= 31; c++) begin
      s = (c >= 10 && c <= 12) || (c >= 18 && c <= 20) || (c >= 30);
      step(1, s, 1);
`ifdef PULSE_MEASURE_PERIOD_EN
      if (period_valid) begin
        if (pv_count < 2) pv_vals[pv_count] = int'(period);
        pv_count++;
      end
`endif
    end
`ifdef PULSE_MEASURE_PERIOD_EN
    check("period_strobes", pv_count, 2);
    check("period_first", pv_vals[0], 8);
    check("period_second", pv_vals[1], 12);
`endif
    step(0, 1, 1);
    check("rst_rise", rise_pulse, 0);
    check("rst_fall", fall_pulse, 0);
    check("rst_width", width, 0);
    check("rst_width_sat", width_sat, 0);
    check("rst_valid", width_valid, 0);
    check("rst_overrun", overrun, 0);
`ifdef PULSE_MEASURE_PERIOD_EN
    check("rst_period", period, 0);
    check("rst_period_valid", period_valid, 0);
`endif
    // Back in ARM: high level after reset must not be measured.
    for (int k = 0; k < 3; k++) step(1, 1, 1);
    check("arm_no_rise", rise_pulse, 0);
    step(1, 0, 1);
    step(1, 1, 1);
    check("arm_then_rise", rise_pulse, 1);
    step(1, 0, 1);
    check("arm_then_width", width, 1);

    // Randomized run against the model.
    cur = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 2) == 0) cur = ~cur;
      if ($urandom_range(0, 299) == 0) step(0, cur, 1'($urandom_range(0, 1)));
      else step(1, cur, ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_measure.md
Name: pulse_measure

Overview:
- Stage directly downstream of the glitch filter. Consumes the filtered, clock-synchronous level `sig_in`.
- Produces one-cycle rise/fall event pulses.
- Measures the width of every high pulse, in clock cycles, and presents it on a valid/ready output port.
- Optionally measures the rise-to-rise period as well.

Parameters:
- CNT_W, 16: width of the pulse-width counter and of the width/period outputs. Legal range 2..32.

Ports:
- clock  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- sig_in  input  1  filtered level, already synchronous to clock.
- rise_pulse  output  1  high for one cycle after a 0->1 transition of sig_in is sampled.
- fall_pulse  output  1  high for one cycle after a 1->0 transition of sig_in is sampled.
- width  output  CNT_W  measured high-pulse width in cycles; valid while width_valid=1.
- width_sat  output  1  accompanies width; 1 if the counter saturated during that pulse.
- width_valid  output  1  result available.
- width_ready  input  1  consumer accepts the result.
- overrun  output  1  sticky; a completed result was dropped.

Behaviour:
- Reset (reset=0 at a clock edge): all of the following are cleared:
  - sig_d=0, state=ARM, cnt=0, cnt_sat=0.
  - rise_pulse=0, fall_pulse=0.
  - width=0, width_sat=0, width_valid=0, overrun=0.
- Reset mid-pulse or mid-handshake discards everything, including a pending result.
- sig_d is sig_in registered once.
- At each edge: rise = sig_in & ~sig_d; fall = ~sig_in & sig_d.
- FSM states: ARM, IDLE, HIGH.
  - ARM: stays in ARM while sig_in=1; moves to IDLE at the first edge sampling sig_in=0. No edge pulses are produced and nothing is counted in ARM. This prevents a partial pulse from being measured at reset release.
  - IDLE: on rise, moves to HIGH with cnt<=1 and cnt_sat<=0; otherwise holds.
  - HIGH: while sig_in=1, cnt<=cnt+1, saturating at 2^CNT_W-1; cnt_sat<=1 when an increment is attempted at the maximum. On fall, moves to IDLE and the result {cnt, cnt_sat} completes.
- rise_pulse/fall_pulse are registered outputs, asserted one cycle in states IDLE/HIGH respectively.
  - rise_pulse is asserted in the cycle after the edge at which rise was detected.
  - fall_pulse is asserted in the cycle after the edge at which fall was detected.
- Width definition: number of edges at which sig_in was sampled 1.
- Latency: width_valid rises at the same edge as fall detection, i.e. it is visible one cycle after the last high sample. fall_pulse is asserted in that same cycle.
- Handshake: a transfer occurs at an edge where width_valid=1 and width_ready=1.
  - width and width_sat are held stable while width_valid=1 and no transfer occurs.
  - On completion with width_valid=0: load the result, width_valid<=1.
  - On completion at an edge where a transfer also occurs: load the new result, width_valid stays 1, no overrun.
  - On completion with width_valid=1 and width_ready=0: keep the old result, set overrun<=1.
  - On a transfer with no completion: width_valid<=0.
  - overrun is cleared only by reset.
- A minimum pulse (one high sample) gives width=1.
- Back-to-back pulses separated by one low sample are measured individually.

Optional Feature:
- Macro: PULSE_MEASURE_PERIOD_EN.
- When defined, adds two outputs:
  - period  output  CNT_W  rise-to-rise distance in cycles.
  - period_valid  output  1  one-cycle strobe, asserted together with rise_pulse; no handshake.
- A free-running counter pcnt runs separately:
  - It is cleared to 1 on each rise.
  - Otherwise it increments, saturating at 2^CNT_W-1.
  - On each rise that is not the first after ARM, the old pcnt value is loaded into period and period_valid<=1.
- Reset values: period=0, period_valid=0, pcnt=0.
- When undefined, these ports, pcnt and the related logic do not exist.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset release with sig_in=1 for 4 cycles, then 0 -> no rise_pulse, no width_valid; state reaches IDLE.
- From IDLE, sig_in high for 5 samples, width_ready=1 -> rise_pulse once; fall_pulse once; width=5 and width_valid=1 for exactly one cycle; width_sat=0.
- CNT_W=4, sig_in high for 20 samples -> width=15, width_sat=1.
- Pulse of 3 samples with width_ready=0, then a pulse of 7 samples with width_ready still 0 -> width holds 3, overrun=1. Then raise width_ready -> one transfer, width_valid=0, overrun stays 1.
- width_ready raised at the same edge that a 2-sample pulse completes while a 6-sample result is pending -> 6 transferred, width=2 loaded, width_valid stays 1, overrun=0.
- With PULSE_MEASURE_PERIOD_EN, rises at cycles 10, 18, 30 -> period_valid pulses twice, with period=8 then period=12. Assert reset=0 mid-pulse -> all outputs return to 0 and state returns to ARM.
